hazard_scoreboard: RTL and testbench

- Parametrised forwarding and stall controller for the MIPS pipeline. It replaces per-opcode decode with a scoreboard of in-flight destination registers, each tagged with a "cycles until result ready" count.
- Decode supplies operand-use times (Tuse) and result-ready times (Tnew). The block tracks producers through DEPTH post-decode stages, generates D- and E-stage forward selects and a decode stall, and owns the multi-cycle mul/div busy counter.

---
 rtl/hazard_scoreboard.sv | 158 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit: tracks in-flight destination registers with a
// cycles-until-ready count and derives decode stall, D/E forward selects and mul/div busy.
module hazard_scoreboard #(
    parameter int RB      = 5,
    parameter int DEPTH   = 3,
    parameter int FW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [RB-1:0] d_rs,
    input  logic [RB-1:0] d_rt,
    input  logic [1:0]    d_rs_tuse,
    input  logic [1:0]    d_rt_tuse,
    input  logic          d_wr_en,
    input  logic [RB-1:0] d_wr_reg,
    input  logic [1:0]    d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    input  logic          flush_e,
    output logic          stall,
    output logic [FW-1:0] fwd_rs_d,
    output logic [FW-1:0] fwd_rt_d,
    output logic [FW-1:0] fwd_rs_e,
    output logic [FW-1:0] fwd_rt_e,
    output logic          md_busy
);

    localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0][RB-1:0] reg_q, reg_d;
    logic [DEPTH-1:0][1:0]    tnew_q, tnew_d;
    logic [RB-1:0]            src_rs_q, src_rs_d;
    logic [RB-1:0]            src_rt_q, src_rt_d;
    logic                     md_start_q, md_start_d;
    logic                     md_div_q, md_div_d;
    logic [CW-1:0]            md_cnt_q, md_cnt_d;

    logic          rs_hit, rt_hit, ers_hit, ert_hit;
    logic [FW-1:0] rs_k, rt_k, ers_k, ert_k;
    logic [1:0]    rs_tn, rt_tn, ers_tn, ert_tn;
    logic          data_stall, md_stall, issue;

    function automatic logic [1:0] tnew_sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Lowest-index (youngest) valid entry writing s; register 0 never matches.
    function automatic void youngest(
        input  logic [RB-1:0]            s,
        input  logic                     skip_e,
        input  logic [DEPTH-1:0]         v,
        input  logic [DEPTH-1:0][RB-1:0] r,
        input  logic [DEPTH-1:0][1:0]    t,
        output logic                     hit,
        output logic [FW-1:0]            k,
        output logic [1:0]               tn
    );
        hit = 1'b0;
        k   = '0;
        tn  = 2'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i] && (r[i] == s) && (s != '0) && !(skip_e && (i == 0))) begin
                hit = 1'b1;
                k   = FW'(i);
                tn  = t[i];
            end
        end
    endfunction

    function automatic logic [FW-1:0] fwd_sel(input logic hit, input logic [FW-1:0] k,
                                              input logic [1:0] tn);
        return (hit && (k != '0) && (tn == 2'd0)) ? k : '0;
    endfunction

    function automatic logic src_stall(input logic hit, input logic [1:0] tn,
                                       input logic [1:0] tuse);
        return (tuse != 2'd3) && hit && (tn > tuse);
    endfunction

    always_comb begin
        youngest(d_rs, 1'b0, vld_q, reg_q, tnew_q, rs_hit, rs_k, rs_tn);
        youngest(d_rt, 1'b0, vld_q, reg_q, tnew_q, rt_hit, rt_k, rt_tn);
        youngest(src_rs_q, 1'b1, vld_q, reg_q, tnew_q, ers_hit, ers_k, ers_tn);
        youngest(src_rt_q, 1'b1, vld_q, reg_q, tnew_q, ert_hit, ert_k, ert_tn);
    end

    // A youngest match still in E yields select 0 for D; the stall covers it when needed.
    assign fwd_rs_d = fwd_sel(rs_hit, rs_k, rs_tn);
    assign fwd_rt_d = fwd_sel(rt_hit, rt_k, rt_tn);
    assign fwd_rs_e = fwd_sel(ers_hit, ers_k, ers_tn);
    assign fwd_rt_e = fwd_sel(ert_hit, ert_k, ert_tn);

    assign data_stall = src_stall(rs_hit, rs_tn, d_rs_tuse) | src_stall(rt_hit, rt_tn, d_rt_tuse);
    assign md_busy    = (md_cnt_q != '0) | md_start_q;
    assign md_stall   = issue_valid & (d_md_start | d_md_use) & md_busy;
    assign stall      = issue_valid & (data_stall | md_stall);
    assign issue      = issue_valid & ~stall & ~flush_e;

    always_comb begin
        vld_d      = '0;
        reg_d      = '0;
        tnew_d     = '0;
        src_rs_d   = '0;
        src_rt_d   = '0;
        md_start_d = 1'b0;
        md_div_d   = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k]  = vld_q[k-1];
            reg_d[k]  = reg_q[k-1];
            tnew_d[k] = tnew_sat_dec(tnew_q[k-1]);
        end
        if (issue) begin
            vld_d[0]   = d_wr_en;
            reg_d[0]   = d_wr_reg;
            tnew_d[0]  = d_tnew;
            src_rs_d   = (d_rs_tuse == 2'd3) ? '0 : d_rs;
            src_rt_d   = (d_rt_tuse == 2'd3) ? '0 : d_rt;
            md_start_d = d_md_start;
            md_div_d   = d_md_div;
        end
        // Counter loads while the mul/div sits in E; md_start_q bridges that cycle in md_busy.
        md_cnt_d = md_cnt_q;
        if (md_start_q) begin
            md_cnt_d = md_div_q ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            reg_q      <= '0;
            tnew_q     <= '0;
            src_rs_q   <= '0;
            src_rt_q   <= '0;
            md_start_q <= 1'b0;
            md_div_q   <= 1'b0;
            md_cnt_q   <= '0;
        end else begin
            vld_q      <= vld_d;
            reg_q      <= reg_d;
            tnew_q     <= tnew_d;
            src_rs_q   <= src_rs_d;
            src_rt_q   <= src_rt_d;
            md_start_q <= md_start_d;
            md_div_q   <= md_div_d;
            md_cnt_q   <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic checked
// against a history-based reference model of what entered E on each recent cycle.
module tb_hazard_scoreboard;
    localparam int RB = 5, DEPTH = 3, FW = 2, MUL_LAT = 5, DIV_LAT = 10;

    logic          clk = 1'b0, rst = 1'b1, issue_valid = 1'b0;
    logic [RB-1:0] d_rs = '0, d_rt = '0, d_wr_reg = '0;
    logic [1:0]    d_rs_tuse = '0, d_rt_tuse = '0, d_tnew = '0;
    logic          d_wr_en = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
    logic          flush_e = 1'b0;
    logic          stall, md_busy;
    logic [FW-1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    hazard_scoreboard #(.RB(RB), .DEPTH(DEPTH), .FW(FW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_wr_en(d_wr_en), .d_wr_reg(d_wr_reg),
        .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .flush_e(flush_e), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // hist[k] = what entered E k cycles ago (k = 0 is the instruction now in E).
    typedef struct {
        bit v;
        int r;
        int tn;
        int srs;
        int srt;
    } ent_t;

    ent_t hist [DEPTH];
    int   md_age = -1;
    int   md_lat = 0;
    int   n_chk = 0, n_pass = 0;
    int   last_stall, last_fwd_rs_d, last_fwd_rs_e, last_fwd_rt_e, last_md_busy;

    task automatic check(string tag, int obs, int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d at t=%0t", tag, obs, exp, $time);
    endtask

    function automatic void reset_model();
        for (int k = 0; k < DEPTH; k++) hist[k] = '{0, 0, 0, 0, 0};
        md_age = -1;
    endfunction

    function automatic int find_k(int s, int first);
        if (s == 0) return -1;
        for (int k = first; k < DEPTH; k++)
            if (hist[k].v && hist[k].r == s) return k;
        return -1;
    endfunction

    // Cycles left before the producer k stages past E can forward.
    function automatic int rem(int k);
        int t = hist[k].tn - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int fwd_of(int k);
        return (k >= 1 && rem(k) == 0) ? k : 0;
    endfunction

    task automatic cycle();
        int  ks, kt;
        bit  ds, busy, st, issued;
        ent_t e;
        #1;
        ks = find_k(int'(d_rs), 0);
        kt = find_k(int'(d_rt), 0);
        ds = 0;
        if (d_rs_tuse != 2'd3 && ks >= 0 && rem(ks) > int'(d_rs_tuse)) ds = 1;
        if (d_rt_tuse != 2'd3 && kt >= 0 && rem(kt) > int'(d_rt_tuse)) ds = 1;
        busy   = (md_age >= 0) && (md_age <= md_lat);
        st     = issue_valid && (ds || ((d_md_start || d_md_use) && busy));
        issued = issue_valid && !st && !flush_e;
        check("stall", int'(stall), int'(st));
        check("fwd_rs_d", int'(fwd_rs_d), fwd_of(ks));
        check("fwd_rt_d", int'(fwd_rt_d), fwd_of(kt));
        check("fwd_rs_e", int'(fwd_rs_e), fwd_of(find_k(hist[0].srs, 1)));
        check("fwd_rt_e", int'(fwd_rt_e), fwd_of(find_k(hist[0].srt, 1)));
        check("md_busy", int'(md_busy), int'(busy));
        last_stall    = int'(stall);
        last_fwd_rs_d = int'(fwd_rs_d);
        last_fwd_rs_e = int'(fwd_rs_e);
        last_fwd_rt_e = int'(fwd_rt_e);
        last_md_busy  = int'(md_busy);
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
            e = '{0, 0, 0, 0, 0};
            if (issued) begin
                e.v   = d_wr_en;
                e.r   = int'(d_wr_reg);
                e.tn  = int'(d_tnew);
                e.srs = (d_rs_tuse == 2'd3) ? 0 : int'(d_rs);
                e.srt = (d_rt_tuse == 2'd3) ? 0 : int'(d_rt);
            end
            hist[0] = e;
            if (md_age >= 0) begin
                md_age++;
                if (md_age > md_lat) md_age = -1;
            end
            if (issued && d_md_start) begin
                md_age = 0;
                md_lat = d_md_div ? DIV_LAT : MUL_LAT;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(bit iv, int rs, int rt, int tus, int tut, bit we, int wr, int tn,
                         bit ms, bit md, bit mu, bit fl);
        issue_valid = iv;
        d_rs        = RB'(rs);
        d_rt        = RB'(rt);
        d_rs_tuse   = 2'(tus);
        d_rt_tuse   = 2'(tut);
        d_wr_en     = we;
        d_wr_reg    = RB'(wr);
        d_tnew      = 2'(tn);
        d_md_start  = ms;
        d_md_div    = md;
        d_md_use    = mu;
        flush_e     = fl;
    endtask

    task automatic idle(int n);
        drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hold the instruction in D until it issues; nst = number of stalled cycles.
    task automatic offer(int rs, int rt, int tus, int tut, bit we, int wr, int tn,
                         bit ms, bit md, bit mu, output int nst);
        bit done = 0;
        nst = 0;
        drive(1, rs, rt, tus, tut, we, wr, tn, ms, md, mu, 0);
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            if (last_stall == 0) done = 1;
            else nst++;
        end
        if (!done) check("issue_timeout", 0, 1);
        drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // addu $3 ; addu $4,$3,$3 -> no stall, then E forwards from M
        offer(1, 2, 1, 1, 1, 3, 1, 0, 0, 0, n);
        offer(3, 3, 1, 1, 1, 4, 1, 0, 0, 0, n);
        check("alu_alu_stalls", n, 0);
        idle(1);
        check("alu_fwd_rs_e", last_fwd_rs_e, 1);
        check("alu_fwd_rt_e", last_fwd_rt_e, 1);
        idle(3);

        // lw $5 ; addu $6,$5 -> one stall, load forwarded from W
        offer(1, 0, 1, 3, 1, 5, 2, 0, 0, 0, n);
        offer(5, 0, 1, 3, 1, 6, 1, 0, 0, 0, n);
        check("load_use_stalls", n, 1);
        idle(1);
        check("load_use_fwd_rs_e", last_fwd_rs_e, 2);
        idle(3);

        // addu $7 ; beq $7 -> one stall then D forwards from M
        offer(1, 2, 1, 1, 1, 7, 1, 0, 0, 0, n);
        offer(7, 0, 0, 3, 0, 0, 0, 0, 0, 0, n);
        check("alu_branch_stalls", n, 1);
        check("alu_branch_fwd_d", last_fwd_rs_d, 1);
        idle(3);

        // lw $7 ; beq $7 -> two stalls then D forwards from W
        offer(1, 0, 1, 3, 1, 7, 2, 0, 0, 0, n);
        offer(7, 0, 0, 3, 0, 0, 0, 0, 0, 0, n);
        check("load_branch_stalls", n, 2);
        check("load_branch_fwd_d", last_fwd_rs_d, 2);
        idle(3);

        // writes to $0 never create hazards
        offer(1, 2, 1, 1, 1, 0, 2, 0, 0, 0, n);
        offer(0, 0, 0, 0, 1, 9, 1, 0, 0, 0, n);
        check("r0_stalls", n, 0);
        check("r0_fwd_d", last_fwd_rs_d, 0);
        idle(3);

        // div ; mflo -> mflo waits out the full busy window
        offer(1, 2, 1, 1, 0, 0, 0, 1, 1, 0, n);
        offer(0, 0, 3, 3, 1, 8, 1, 0, 0, 1, n);
        check("div_mflo_stalls", n, DIV_LAT + 1);
        check("div_mflo_busy_at_issue", last_md_busy, 0);
        idle(3);

        // reset during div with a load in flight
        offer(1, 2, 1, 1, 0, 0, 0, 1, 1, 0, n);
        offer(1, 0, 1, 3, 1, 9, 2, 0, 0, 0, n);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        offer(9, 9, 0, 0, 1, 10, 1, 0, 0, 0, n);
        check("post_reset_stalls", n, 0);
        check("post_reset_md_busy", last_md_busy, 0);
        idle(3);

        // random traffic over a small register set to keep hazards frequent
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) < 8,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
